dmem_responder: RTL and testbench

- Responder (memory side) of the CPU data-memory interface: `mem_data` (shared bidirectional), `mem_rw`, `addr`, plus a `mem_req`/`mem_ready` handshake with programmable wait states.
- Sits between the `top` CPU core and the storage array. It replaces the zero-latency data memory so the core's stall path can be exercised.
- Also provides a halt mailbox so simulation can end on a CPU store.

---
 rtl/dmem_responder_if.sv | 11 +
 rtl/dmem_responder.sv | 122 ++++++++++++
 tb/tb_dmem_responder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the CPU data port and dmem_responder.
// The shared 64-bit data bus is a tristate net and stays a plain inout port on the responder.
interface dmem_responder_if;
  logic        mem_req;
  logic        mem_ready;
  logic        mem_rw;
  logic [63:0] addr;

  modport master (output mem_req, output mem_rw, output addr, input mem_ready);
  modport slave  (input mem_req, input mem_rw, input addr, output mem_ready);
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states, one-cycle ready strobe and halt mailbox.
// Optional out-of-range checking is enabled by defining DMEM_BOUNDS_CHECK_EN.
module dmem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned ADDR_LSB    = 3,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned HALT_WORD   = 255
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [63:0]       mem_data,
  dmem_responder_if.slave   bus,
  output logic              halt,
  output logic              err
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam logic [63:0] OOB_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            rw_q;
  logic [IW-1:0]   idx_q;
  logic [63:0]     wdata_q;
  logic            oob_q;
  logic [63:0]     rdata_q;
  logic            ready_q;
  logic            bus_en;
  logic            err_q;
  logic [63:0]     mem [DEPTH];

  logic [IW-1:0]   idx_in;
  logic            oob_in;
  logic            enter_resp;
  logic            fin_rw;
  logic [IW-1:0]   fin_idx;
  logic [63:0]     fin_data;
  logic            fin_oob;

  assign idx_in = bus.addr[ADDR_LSB +: IW];

`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob_in = ((bus.addr >> ADDR_LSB) >= 64'(DEPTH)) || (bus.addr[ADDR_LSB-1:0] != '0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[63:ADDR_LSB+IW], bus.addr[ADDR_LSB-1:0]};
  assign oob_in = 1'b0;
`endif

  // With zero wait states the commit happens at the accept edge, so use the live bus values.
  always_comb begin
    fin_rw     = rw_q;
    fin_idx    = idx_q;
    fin_data   = wdata_q;
    fin_oob    = oob_q;
    enter_resp = 1'b0;
    if (state == IDLE) begin
      fin_rw   = bus.mem_rw;
      fin_idx  = idx_in;
      fin_data = mem_data;
      fin_oob  = oob_in;
      enter_resp = bus.mem_req && (WAIT_STATES == 0);
    end else if (state == WAIT) begin
      enter_resp = (cnt == 4'd1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rw_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      oob_q   <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      bus_en  <= 1'b0;
      halt    <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[IW'(i)] <= '0;
    end else begin
      ready_q <= 1'b0;
      bus_en  <= 1'b0;
      case (state)
        IDLE: if (bus.mem_req) begin
          rw_q    <= bus.mem_rw;
          idx_q   <= idx_in;
          wdata_q <= mem_data;
          oob_q   <= oob_in;
          cnt     <= 4'(WAIT_STATES);
          state   <= WAIT;
        end
        WAIT:    cnt   <= cnt - 4'd1;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // RESP entry overrides the case above: it is the single commit point for both paths.
      if (enter_resp) begin
        state   <= RESP;
        ready_q <= 1'b1;
        bus_en  <= !fin_rw;
        err_q   <= err_q | fin_oob;
        if (fin_rw) begin
          if (!fin_oob) begin
            mem[fin_idx] <= fin_data;
            if (fin_idx == IW'(HALT_WORD)) halt <= 1'b1;
          end
        end else begin
          rdata_q <= fin_oob ? OOB_DATA : mem[fin_idx];
        end
      end
    end
  end

  assign bus.mem_ready = ready_q;
  assign mem_data      = bus_en ? rdata_q : 'z;
  assign err           = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed scenarios plus random traffic vs a word-array model.
module tb_dmem_responder;

  localparam int unsigned WS = 2;
  localparam logic [63:0] DEAD = 64'hDEAD_BEEF_DEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if bif ();
  dmem_responder_if bif0 ();
  wire [63:0] mem_data;
  wire [63:0] mem_data0;
  logic        tb_drive_en = 1'b0;
  logic [63:0] tb_wdata = '0;
  logic halt, err, halt0, err0;

  assign mem_data = tb_drive_en ? tb_wdata : 'z;

  dmem_responder #(.WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst_n), .mem_data(mem_data), .bus(bif.slave), .halt(halt), .err(err)
  );

  dmem_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst_n), .mem_data(mem_data0), .bus(bif0.slave), .halt(halt0), .err(err0)
  );

  typedef struct {
    int unsigned cyc;
    bit          rw;
    logic [63:0] data;
    bit          halt;
    bit          err;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] model [256];
  bit          halt_exp = 0;
  bit          err_exp = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model[i] = '0;
    halt_exp = 0;
    err_exp  = 0;
  endtask

  // Monitor: every ready strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bif.mem_ready) begin
        if (sbq.size() == 0) begin
          chk(1'b0, "unexpected_ready", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk(cyc == e.cyc, "ready_latency", 64'(cyc), 64'(e.cyc));
          chk(dut.bus_en == !e.rw, "bus_drive_in_resp", 64'(dut.bus_en), 64'(!e.rw));
          if (!e.rw) chk(mem_data == e.data, "read_data", mem_data, e.data);
          chk(halt == e.halt, "halt", 64'(halt), 64'(e.halt));
          chk(err == e.err, "err", 64'(err), 64'(e.err));
        end
      end else begin
        chk(dut.bus_en == 1'b0, "bus_released", 64'(dut.bus_en), 64'd0);
      end
    end
  end

  task automatic issue(input bit rw, input logic [63:0] a, input logic [63:0] d);
    exp_t e;
    logic [7:0] idx;
    bit oob;
    bit got;
    @(negedge clk);
    bif.mem_req = 1'b1;
    bif.mem_rw  = rw;
    bif.addr    = a;
    tb_wdata    = d;
    tb_drive_en = rw;
    idx = a[10:3];
    oob = 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
    oob = ((a >> 3) >= 64'd256) || (a[2:0] != 3'd0);
`endif
    e.cyc  = cyc + 1 + WS;
    e.rw   = rw;
    e.data = '0;
    if (rw) begin
      if (!oob) begin
        model[idx] = d;
        if (idx == 8'd255) halt_exp = 1;
      end
    end else begin
      e.data = oob ? DEAD : model[idx];
    end
    if (oob) err_exp = 1;
    e.halt = halt_exp;
    e.err  = err_exp;
    sbq.push_back(e);
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bif.mem_ready) got = 1;
    end
    if (!got) chk(1'b0, "ready_timeout", 64'd0, 64'd1);
    bif.mem_req = 1'b0;
    tb_drive_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    bit prev, consec;
    bif.mem_req = 1'b0; bif.mem_rw = 1'b0; bif.addr = '0;
    bif0.mem_req = 1'b0; bif0.mem_rw = 1'b0; bif0.addr = '0;
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk(bif.mem_ready == 1'b0, "reset_ready", 64'(bif.mem_ready), 64'd0);
    chk(halt == 1'b0, "reset_halt", 64'(halt), 64'd0);
    chk(err == 1'b0, "reset_err", 64'(err), 64'd0);

    // Reset contents, basic write/readback, halt mailbox.
    issue(1'b0, 64'h40, '0);
    issue(1'b1, 64'h18, 64'h1122334455667788);
    issue(1'b0, 64'h18, '0);
    issue(1'b1, 64'h0, 64'h0);
    issue(1'b1, 64'h7F8, 64'hCAFE_0000_1234_5678);
    issue(1'b0, 64'h0, '0);
    issue(1'b0, 64'h7F8, '0);

    // Zero-wait-state instance with request held high: ready on alternate cycles.
    @(negedge clk);
    bif0.mem_req = 1'b1; bif0.mem_rw = 1'b0; bif0.addr = 64'h08;
    pulses = 0; prev = 0; consec = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bif0.mem_ready) begin
        pulses++;
        if (prev) consec = 1;
        chk(mem_data0 == 64'd0, "ws0_read_data", mem_data0, 64'd0);
      end
      prev = bif0.mem_ready;
    end
    bif0.mem_req = 1'b0;
    chk(pulses == 3, "ws0_pulse_count", 64'(pulses), 64'd3);
    chk(consec == 0, "ws0_no_back_to_back", 64'(consec), 64'd0);

    // Reset one cycle after accepting a write: nothing commits, no ready.
    @(negedge clk);
    bif.mem_req = 1'b1; bif.mem_rw = 1'b1; bif.addr = 64'h10;
    tb_wdata = 64'hAA; tb_drive_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; bif.mem_req = 1'b0; tb_drive_en = 1'b0;
    #1;
    chk(bif.mem_ready == 1'b0, "abort_ready", 64'(bif.mem_ready), 64'd0);
    chk(dut.bus_en == 1'b0, "abort_bus", 64'(dut.bus_en), 64'd0);
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk(halt == 1'b0, "abort_halt", 64'(halt), 64'd0);
    chk(err == 1'b0, "abort_err", 64'(err), 64'd0);
    issue(1'b0, 64'h10, '0);

    // Address beyond the array and misaligned address.
    issue(1'b1, 64'h0, 64'h77);
    issue(1'b0, 64'h800, '0);
    issue(1'b1, 64'h804, 64'h5);
    issue(1'b0, 64'h0, '0);

    // Random traffic, biased toward a few words so reads hit earlier writes.
    for (int n = 0; n < 120; n++) begin
      int unsigned r;
      logic [63:0] a;
      r = $urandom_range(0, 9);
      if (r < 8)       a = 64'(r) << 3;
      else if (r == 8) a = 64'h7F8;
      else             a = 64'($urandom_range(0, 255)) << 3;
      if ($urandom_range(0, 7) == 0) a = a | (64'($urandom) << 11);
      if ($urandom_range(0, 7) == 0) a = a | 64'($urandom_range(1, 7));
      issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom});
    end

    repeat (4) @(negedge clk);
    chk(sbq.size() == 0, "scoreboard_drained", 64'(sbq.size()), 64'd0);
    chk(halt0 == 1'b0 && err0 == 1'b0, "ws0_flags", {62'd0, halt0, err0}, 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
